// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch PC sequencing with boot, redirect and flush bubbles.
// Trap support (trap_req, epc) is built only with PC_CTRL_TRAP_EN.
module pc_ctrl #(
  parameter logic [31:0] RESET_VEC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
`ifdef PC_CTRL_TRAP_EN
  input  logic        trap_req,
`endif
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_en,
  output logic        fetch_valid,
  output logic        flush
`ifdef PC_CTRL_TRAP_EN
  ,
  output logic [31:0] epc
`endif
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_FLUSH
  } state_e;

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        trap;
  logic [31:0] seq_pc;
  logic [31:0] br_pc;

  assign seq_pc = pc_cur + 32'd4;
  assign br_pc  = br_target & 32'hFFFF_FFFC;

`ifdef PC_CTRL_TRAP_EN
  logic [31:0] epc_q, epc_d;

  // A misaligned redirect target is treated as a trap.
  assign trap = trap_req
              | (br_taken & (br_target[1:0] != 2'b00));
  assign epc  = epc_q;
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_next     = seq_pc;
    pc_en       = !stall;
    fetch_valid = 1'b0;
    flush       = 1'b1;
`ifdef PC_CTRL_TRAP_EN
    epc_d       = epc_q;
`endif
    unique case (state_q)
      S_BOOT: begin
        pc_next = RESET_VEC;
        pc_en   = 1'b1;
        state_d = S_RUN;
      end
      S_RUN, S_FLUSH: begin
        if (trap) begin
          pc_next = TRAP_VEC;
          pc_en   = 1'b1;
          cnt_d   = FC;
          state_d = S_FLUSH;
`ifdef PC_CTRL_TRAP_EN
          epc_d   = pc_cur;
`endif
        end else if (br_taken) begin
          pc_next = br_pc;
          pc_en   = 1'b1;
          cnt_d   = FC;
          state_d = S_FLUSH;
        end else if (state_q == S_RUN) begin
          fetch_valid = !stall;
          flush       = 1'b0;
        end else if (pc_en) begin
          // Bubbles only count when the PC actually advances.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = S_RUN;
          end
        end
      end
      default: begin
        state_d = S_BOOT;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef PC_CTRL_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc_q <= 32'd0;
    end else begin
      epc_q <= epc_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// tb_pc_ctrl: directed and random checks of pc_ctrl against a
// cycle-level reference model; the bench owns the PC register.
module tb_pc_ctrl;

  localparam logic [31:0] RVEC = 32'h0000_0000;
  localparam logic [31:0] TVEC = 32'h0000_0100;
  localparam int          NFL  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic [31:0] pc_reg = 32'hDEAD_BEE0;
  logic [31:0] pc_next;
  logic        pc_en;
  logic        fetch_valid;
  logic        flush;
`ifdef PC_CTRL_TRAP_EN
  logic        trap_req = 1'b0;
  logic        trap_in = 1'b0;
  logic [31:0] epc;
  logic [31:0] o_epc;
`endif

  int checks = 0;
  int fails = 0;

  // model state: booting flag, bubbles still owed, saved trap PC
  bit          m_boot = 1'b1;
  int          m_bub = 0;
  logic [31:0] m_epc = 32'd0;

  logic [34:0] o_v, e_v;
  logic        o_en, o_fv, o_fl;
  logic [31:0] o_next;

  pc_ctrl dut (
    .clk(clk),
    .reset(rst_n),
    .stall(stall),
    .br_taken(br_taken),
    .br_target(br_target),
`ifdef PC_CTRL_TRAP_EN
    .trap_req(trap_req),
`endif
    .pc_cur(pc_reg),
    .pc_next(pc_next),
    .pc_en(pc_en),
    .fetch_valid(fetch_valid),
    .flush(flush)
`ifdef PC_CTRL_TRAP_EN
    ,
    .epc(epc)
`endif
  );

  always #5 clk = ~clk;

  // One clock: starts and ends 1 time unit after a rising edge.
  task automatic cyc(input logic s, input logic b,
                     input logic [31:0] t);
    logic        trap_ev;
    logic [31:0] pc0;
    trap_ev   = 1'b0;
    pc0       = pc_reg;
    stall     = s;
    br_taken  = b;
    br_target = t;
`ifdef PC_CTRL_TRAP_EN
    trap_req  = trap_in;
    trap_ev   = trap_in || (b && (t % 4 != 0));
`endif
    if (!rst_n || m_boot)
      e_v = {RVEC, 3'b101};
    else if (trap_ev)
      e_v = {TVEC, 3'b101};
    else if (b)
      e_v = {(t / 4) * 4, 3'b101};
    else if (m_bub > 0)
      e_v = {pc0 + 32'd4, !s, 2'b01};
    else
      e_v = {pc0 + 32'd4, !s, !s, 1'b0};
    #4;
    o_next = pc_next;
    o_en   = pc_en;
    o_fv   = fetch_valid;
    o_fl   = flush;
    o_v    = {o_next, o_en, o_fv, o_fl};
    @(posedge clk);
    #1;
    if (o_en) pc_reg = o_next;
    if (!rst_n) begin
      m_boot = 1'b1;
      m_bub  = 0;
      m_epc  = 32'd0;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_bub  = 0;
    end else if (trap_ev) begin
      m_bub = NFL;
      m_epc = pc0;
    end else if (b) begin
      m_bub = NFL;
    end else if (m_bub > 0 && !s) begin
      m_bub = m_bub - 1;
    end
`ifdef PC_CTRL_TRAP_EN
    o_epc = epc;
`endif
  endtask

  // Land in RUN at addr via a redirect and its bubbles.
  task automatic goto(input logic [31:0] addr);
    cyc(1'b0, 1'b1, addr - 32'(4 * NFL));
    repeat (NFL) cyc(1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_next, pc_en, fetch_valid, flush} !== {RVEC, 3'b101}) begin
      fails++;
      $display("FAIL reset_async: got %h/%b%b%b want %h/101",
               pc_next, pc_en, fetch_valid, flush, RVEC);
    end
    @(posedge clk);
    #1;
    repeat (3) begin
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom);
      checks++;
      if (o_v !== e_v) begin
        fails++;
        $display("FAIL reset_hold: got %h want %h", o_v, e_v);
      end
    end
    rst_n = 1'b1;
    cyc(1'b1, 1'b1, 32'h40);
    checks++;
    if (o_v !== e_v || pc_reg !== RVEC) begin
      fails++;
      $display("FAIL boot: got %h pc=%h want %h pc=%h",
               o_v, pc_reg, e_v, RVEC);
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b0, 32'd0);
      checks++;
      if (o_v !== e_v || o_fv !== 1'b1 || pc_reg !== 32'(4 * i)) begin
        fails++;
        $display("FAIL boot_seq: got %h pc=%h want %h pc=%h",
                 o_v, pc_reg, e_v, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall;
    goto(32'h10);
    repeat (3) begin
      cyc(1'b1, 1'b0, 32'd0);
      checks++;
      if (o_v !== e_v || o_en !== 1'b0 || pc_reg !== 32'h10) begin
        fails++;
        $display("FAIL stall_hold: got %h pc=%h want %h pc=10",
                 o_v, pc_reg, e_v);
      end
    end
    cyc(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_v !== e_v || pc_reg !== 32'h14) begin
      fails++;
      $display("FAIL stall_release: got pc=%h want pc=14", pc_reg);
    end
  endtask

  task automatic test_branch;
    logic [31:0] pre;
    int nfl;
    bit seen;
    goto(32'h20);
    cyc(1'b1, 1'b1, 32'h400);
    checks++;
    if (o_v !== e_v || pc_reg !== 32'h400) begin
      fails++;
      $display("FAIL branch_stall: got %h pc=%h want %h pc=400",
               o_v, pc_reg, e_v);
    end
    nfl  = 1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      pre = pc_reg;
      cyc(1'b0, 1'b0, 32'd0);
      checks++;
      if (o_v !== e_v) begin
        fails++;
        $display("FAIL branch_bubble: got %h want %h", o_v, e_v);
      end
      if (o_fl) nfl++;
      if (o_fv) begin
        seen = 1'b1;
        checks++;
        if (pre !== 32'h408 || nfl !== NFL + 1) begin
          fails++;
          $display("FAIL branch_latency: got pc=%h flushes=%0d want pc=408 flushes=%0d",
                   pre, nfl, NFL + 1);
        end
      end
    end
    checks++;
    if (!seen) begin
      fails++;
      $display("FAIL branch_timeout: got no fetch_valid want one");
    end
  endtask

  task automatic test_rebranch;
    goto(32'h30);
    cyc(1'b0, 1'b1, 32'h200);
    cyc(1'b0, 1'b0, 32'd0);
    checks++;
    if (dut.cnt_q !== 3'd1) begin
      fails++;
      $display("FAIL rebranch_pre: got cnt=%0d want 1", dut.cnt_q);
    end
    cyc(1'b0, 1'b1, 32'h800);
    checks++;
    if (o_v !== e_v || pc_reg !== 32'h800 || dut.cnt_q !== 3'd2) begin
      fails++;
      $display("FAIL rebranch: got pc=%h cnt=%0d want pc=800 cnt=2",
               pc_reg, dut.cnt_q);
    end
    repeat (2) begin
      cyc(1'b0, 1'b0, 32'd0);
      checks++;
      if (o_v !== e_v || o_fv !== 1'b0 || o_fl !== 1'b1) begin
        fails++;
        $display("FAIL rebranch_bubble: got %h want %h", o_v, e_v);
      end
    end
    cyc(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_v !== e_v || o_fv !== 1'b1 || o_next !== 32'h80C) begin
      fails++;
      $display("FAIL rebranch_run: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_misaligned;
    goto(32'h60);
    cyc(1'b0, 1'b1, 32'h402);
    checks++;
`ifdef PC_CTRL_TRAP_EN
    if (o_v !== e_v || pc_reg !== TVEC || o_epc !== 32'h60) begin
      fails++;
      $display("FAIL misaligned_trap: got pc=%h epc=%h want pc=%h epc=60",
               pc_reg, o_epc, TVEC);
    end
`else
    if (o_v !== e_v || pc_reg !== 32'h400 || o_fl !== 1'b1) begin
      fails++;
      $display("FAIL misaligned: got pc=%h want pc=400", pc_reg);
    end
`endif
  endtask

`ifdef PC_CTRL_TRAP_EN
  task automatic test_trap;
    goto(32'h44);
    trap_in = 1'b1;
    cyc(1'b0, 1'b1, 32'h400);
    checks++;
    if (o_v !== e_v || pc_reg !== TVEC || o_epc !== 32'h44) begin
      fails++;
      $display("FAIL trap: got pc=%h epc=%h want pc=%h epc=44",
               pc_reg, o_epc, TVEC);
    end
    cyc(1'b1, 1'b0, 32'd0);
    trap_in = 1'b0;
    checks++;
    if (o_v !== e_v || pc_reg !== TVEC || o_epc !== TVEC) begin
      fails++;
      $display("FAIL trap_in_flush: got pc=%h epc=%h want pc=%h epc=%h",
               pc_reg, o_epc, TVEC, TVEC);
    end
  endtask
`endif

  task automatic test_wrap;
    goto(32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_v !== e_v || pc_reg !== 32'd0 || o_fv !== 1'b1) begin
      fails++;
      $display("FAIL wrap: got %h pc=%h want %h pc=0",
               o_v, pc_reg, e_v);
    end
  endtask

  task automatic test_reset_mid_flush;
    goto(32'h80);
    cyc(1'b0, 1'b1, 32'h300);
    cyc(1'b0, 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pc_next, pc_en, fetch_valid, flush} !== {RVEC, 3'b101}
        || dut.cnt_q !== 3'd0) begin
      fails++;
      $display("FAIL reset_mid_flush: got %h/%b%b%b cnt=%0d want %h/101 cnt=0",
               pc_next, pc_en, fetch_valid, flush, dut.cnt_q, RVEC);
    end
`ifdef PC_CTRL_TRAP_EN
    checks++;
    if (epc !== 32'd0) begin
      fails++;
      $display("FAIL reset_epc: got %h want 0", epc);
    end
`endif
    @(posedge clk);
    #1;
    pc_reg = RVEC;
    m_boot = 1'b1;
    m_bub  = 0;
    m_epc  = 32'd0;
    cyc(1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_v !== e_v || pc_reg !== RVEC) begin
      fails++;
      $display("FAIL reset_reboot: got pc=%h want pc=%h", pc_reg, RVEC);
    end
    cyc(1'b0, 1'b0, 32'd0);
    checks++;
    if (o_v !== e_v || o_fv !== 1'b1 || o_fl !== 1'b0) begin
      fails++;
      $display("FAIL reset_residue: got %h want %h", o_v, e_v);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 40) != 0);
`ifdef PC_CTRL_TRAP_EN
      trap_in = ($urandom_range(0, 9) == 0);
`endif
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          ($urandom_range(0, 2) == 0) ? $urandom
                                      : ($urandom & 32'hFFFF_FFFC));
      checks++;
      if (o_v !== e_v) begin
        fails++;
        $display("FAIL random[%0d]: got %h want %h", i, o_v, e_v);
      end
`ifdef PC_CTRL_TRAP_EN
      checks++;
      if (o_epc !== m_epc) begin
        fails++;
        $display("FAIL random_epc[%0d]: got %h want %h", i, o_epc, m_epc);
      end
`endif
    end
    rst_n = 1'b1;
`ifdef PC_CTRL_TRAP_EN
    trap_in = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_rebranch();
    test_misaligned();
`ifdef PC_CTRL_TRAP_EN
    test_trap();
`endif
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
